// File: rtl/booth_sequencer_if.sv
// rtl/booth_sequencer_if.sv - operand/result bundle between keypad FSM and Booth sequencer
interface booth_sequencer_if #(
  parameter int WIDTH = 8
);
  logic                 start;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start, multiplicand, multiplier,
    input  busy, done, product
  );

  modport slave (
    input  start, multiplicand, multiplier,
    output busy, done, product
  );
endinterface

// File: rtl/booth_sequencer.sv
// rtl/booth_sequencer.sv - radix-2 Booth multiplier, one add/sub-and-shift step per clock
module booth_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  booth_sequencer_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                state_q;
  logic signed [WIDTH:0] acc_q, mcand_q;
  logic signed [WIDTH:0] t_d, acc_d;
  logic [WIDTH-1:0]      q_q, q_d;
  logic                  qm1_q, qm1_d;
  logic [CW-1:0]         count_q;
  logic [2*WIDTH-1:0]    product_q;
  logic                  done_q, busy_q;

  // acc carries one guard bit so -2^(WIDTH-1) operands cannot overflow the partial sum.
  always_comb begin
    case ({q_q[0], qm1_q})
      2'b01:   t_d = acc_q + mcand_q;
      2'b10:   t_d = acc_q - mcand_q;
      default: t_d = acc_q;
    endcase
    acc_d = {t_d[WIDTH], t_d[WIDTH:1]};
    q_d   = {t_d[0], q_q[WIDTH-1:1]};
    qm1_d = q_q[0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      q_q       <= '0;
      qm1_q     <= 1'b0;
      count_q   <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            acc_q   <= '0;
            q_q     <= bus.multiplier;
            qm1_q   <= 1'b0;
            mcand_q <= {bus.multiplicand[WIDTH-1], bus.multiplicand};
            count_q <= CW'(WIDTH);
            busy_q  <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          acc_q   <= acc_d;
          q_q     <= q_d;
          qm1_q   <= qm1_d;
          count_q <= count_q - CW'(1);
          if (count_q == CW'(1)) begin
            product_q <= {acc_d[WIDTH-1:0], q_d};
            done_q    <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;
endmodule
